// File: rtl/mpt_pkg.sv
// Shared types for the MPT walker: arbiter FSM encoding and an ID width helper.
package mpt_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } walk_arb_state_e;

  // Requester IDs need at least one bit even for a single-level build.
  function automatic int id_width(input int num_levels);
    return (num_levels > 1) ? $clog2(num_levels) : 1;
  endfunction

endpackage

// File: rtl/mpt_id_fifo.sv
// Synchronous requester-ID FIFO; a push is accepted when full if a pop happens in the same cycle.
module mpt_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= next_ptr(wptr_q);
      if (do_pop)  rptr_q <= next_ptr(rptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mpt_walk_mem_arbiter.sv
// Round-robin arbiter sharing one memory master port between the MPT walk levels.
// Optional per-level grant counters are enabled by defining MPT_WALK_ARB_PERF_CNT_EN.
module mpt_walk_mem_arbiter
  import mpt_pkg::*;
#(
  parameter int NUM_LEVELS                    = 3,
  parameter int MEMORY_TRANSACTION_DATA_WIDTH = 64,
  parameter int MEMORY_TRANSACTION_ADDR_WIDTH = 64,
  parameter int MAX_OUTSTANDING               = 4
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_ni,
  input  logic [NUM_LEVELS-1:0]                                 level_mem_req_i,
  output logic [NUM_LEVELS-1:0]                                 level_mem_gnt_o,
  output logic [NUM_LEVELS-1:0]                                 level_mem_valid_o,
  input  logic [NUM_LEVELS*MEMORY_TRANSACTION_ADDR_WIDTH-1:0]   level_mem_addr_i,
  input  logic [NUM_LEVELS*MEMORY_TRANSACTION_DATA_WIDTH-1:0]   level_mem_wdata_i,
  input  logic [NUM_LEVELS-1:0]                                 level_mem_we_i,
  input  logic [NUM_LEVELS*MEMORY_TRANSACTION_DATA_WIDTH/8-1:0] level_mem_be_i,
  output logic [MEMORY_TRANSACTION_DATA_WIDTH-1:0]              level_mem_rdata_o,
  output logic [NUM_LEVELS-1:0]                                 level_mem_error_o,
  output logic                                                  memory_master_mem_req,
  output logic [MEMORY_TRANSACTION_ADDR_WIDTH-1:0]              memory_master_mem_addr,
  output logic [MEMORY_TRANSACTION_DATA_WIDTH-1:0]              memory_master_mem_wdata,
  output logic                                                  memory_master_mem_we,
  output logic [MEMORY_TRANSACTION_DATA_WIDTH/8-1:0]            memory_master_mem_be,
  input  logic                                                  memory_master_mem_gnt,
  input  logic                                                  memory_master_mem_valid,
  input  logic [MEMORY_TRANSACTION_DATA_WIDTH-1:0]              memory_master_mem_rdata,
  input  logic                                                  memory_master_mem_error,
`ifdef MPT_WALK_ARB_PERF_CNT_EN
  input  logic                                                  perf_clear_i,
  output logic [NUM_LEVELS*32-1:0]                              grant_count_o,
`endif
  output logic                                                  spurious_rsp_o
);

  localparam int DW  = MEMORY_TRANSACTION_DATA_WIDTH;
  localparam int AW  = MEMORY_TRANSACTION_ADDR_WIDTH;
  localparam int BW  = DW / 8;
  localparam int IDW = id_width(NUM_LEVELS);

  walk_arb_state_e state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  locked_id_q;
  logic [IDW-1:0]  sel_id;
  logic [IDW-1:0]  cur_id;
  logic [IDW-1:0]  head_id;
  logic            any_req;
  logic            push_ok;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic            spurious_q;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == IDW'(NUM_LEVELS - 1)) ? '0 : id + 1'b1;
  endfunction

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    int idx;
    idx     = 0;
    sel_id  = '0;
    any_req = 1'b0;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_LEVELS) idx = idx - NUM_LEVELS;
      if (level_mem_req_i[idx]) begin
        sel_id  = IDW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign cur_id  = (state_q == ARB_HOLD) ? locked_id_q : sel_id;
  assign push_ok = !fifo_full || memory_master_mem_valid;
  assign pop     = memory_master_mem_valid && !fifo_empty;

  assign memory_master_mem_addr  = level_mem_addr_i[int'(cur_id)*AW +: AW];
  assign memory_master_mem_wdata = level_mem_wdata_i[int'(cur_id)*DW +: DW];
  assign memory_master_mem_we    = level_mem_we_i[cur_id];
  assign memory_master_mem_be    = level_mem_be_i[int'(cur_id)*BW +: BW];

  always_comb begin
    state_d               = state_q;
    memory_master_mem_req = 1'b0;
    push                  = 1'b0;
    level_mem_gnt_o       = '0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req && push_ok) begin
          memory_master_mem_req = 1'b1;
          if (memory_master_mem_gnt) begin
            push                    = 1'b1;
            level_mem_gnt_o[sel_id] = 1'b1;
          end else begin
            state_d = ARB_HOLD;
          end
        end
      end
      ARB_HOLD: begin
        // A locked level that withdraws its request is abandoned without a push.
        if (!level_mem_req_i[locked_id_q]) begin
          state_d = ARB_IDLE;
        end else if (push_ok) begin
          memory_master_mem_req = 1'b1;
          if (memory_master_mem_gnt) begin
            push                         = 1'b1;
            level_mem_gnt_o[locked_id_q] = 1'b1;
            state_d                      = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      locked_id_q <= '0;
      spurious_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) rr_ptr_q <= next_id(cur_id);
      if (state_q == ARB_IDLE && state_d == ARB_HOLD) locked_id_q <= sel_id;
      if (memory_master_mem_valid && fifo_empty) spurious_q <= 1'b1;
    end
  end

  mpt_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (cur_id),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    level_mem_valid_o = '0;
    level_mem_error_o = '0;
    if (pop) begin
      level_mem_valid_o[head_id] = 1'b1;
      level_mem_error_o[head_id] = memory_master_mem_error;
    end
  end

  assign level_mem_rdata_o = memory_master_mem_rdata;
  assign spurious_rsp_o    = spurious_q;

`ifdef MPT_WALK_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt_q [NUM_LEVELS];

  for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_perf
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        grant_cnt_q[g] <= '0;
      end else if (perf_clear_i) begin
        grant_cnt_q[g] <= '0;
      end else if (level_mem_gnt_o[g] && grant_cnt_q[g] != '1) begin
        grant_cnt_q[g] <= grant_cnt_q[g] + 1'b1;
      end
    end
    assign grant_count_o[g*32 +: 32] = grant_cnt_q[g];
  end
`endif

endmodule
